// File: rtl/tlb_array_if.sv
// Lookup, fill, invalidate and statistics signals of the tlb_array translation cache.
// master drives requests (MMU side), slave is the TLB array.
interface tlb_array_if;
   logic        lookup_valid;
   logic [31:0] lookup_ea;
   logic        rsp_valid;
   logic        rsp_hit;
   logic [31:0] rsp_pa;
   logic [1:0]  rsp_pp;
   logic        rsp_Ks;
   logic        rsp_Kp;
   logic        rsp_cacheable;
   logic        load;
   logic [31:0] new_ea;
   logic [31:0] new_pa;
   logic [1:0]  new_pp;
   logic        new_Kp;
   logic        new_Ks;
   logic        new_cacheable;
   logic [1:0]  invalidate;
   logic [31:0] inval_ea;
   logic        stats_clear;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   modport master (
      output lookup_valid, lookup_ea, load, new_ea, new_pa, new_pp, new_Kp, new_Ks,
             new_cacheable, invalidate, inval_ea, stats_clear,
      input  rsp_valid, rsp_hit, rsp_pa, rsp_pp, rsp_Ks, rsp_Kp, rsp_cacheable,
             hit_count, miss_count
   );

   modport slave (
      input  lookup_valid, lookup_ea, load, new_ea, new_pa, new_pp, new_Kp, new_Ks,
             new_cacheable, invalidate, inval_ea, stats_clear,
      output rsp_valid, rsp_hit, rsp_pa, rsp_pp, rsp_Ks, rsp_Kp, rsp_cacheable,
             hit_count, miss_count
   );
endinterface

// File: rtl/tlb_array.sv
// Fully-associative 4KB-page TLB with registered lookup, victim-selecting fill and invalidate.
// Define TLB_ARRAY_STATS_EN to build saturating hit/miss counters; otherwise they read 0.
module tlb_array #(
   parameter int unsigned ENTRIES     = 8,
   parameter int unsigned INSTRUCTION = 0,
   parameter int unsigned INVAL_BITS  = 6
) (
   input logic        clk,
   input logic        reset,
   tlb_array_if.slave bus
);
   localparam int unsigned IDX_W = $clog2(ENTRIES);

   typedef struct packed {
      logic [19:0] vpn;
      logic [19:0] ppn;
      logic [1:0]  pp;
      logic        ks;
      logic        kp;
      logic        wb;
   } entry_t;

   logic [ENTRIES-1:0] r_valid;
   entry_t             r_entry [ENTRIES];
   logic [IDX_W-1:0]   r_rr;

   logic               w_hit;
   logic [IDX_W-1:0]   w_hit_idx;
   entry_t             w_hit_entry;
   logic               w_dup;
   logic [IDX_W-1:0]   w_dup_idx;
   logic               w_free;
   logic [IDX_W-1:0]   w_free_idx;
   logic [IDX_W-1:0]   w_victim;
   logic [ENTRIES-1:0] w_inval_mask;
   logic               w_inval_all;
   logic               w_inval_ea;
   logic               w_do_load;
   logic               w_unused_addr;

   // Priority encoders: descending scan so the lowest matching index is kept.
   always_comb begin
      w_hit        = 1'b0;
      w_hit_idx    = '0;
      w_dup        = 1'b0;
      w_dup_idx    = '0;
      w_free       = 1'b0;
      w_free_idx   = '0;
      w_inval_mask = '0;
      for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
         if (r_valid[i] && (r_entry[i].vpn == bus.lookup_ea[31:12])) begin
            w_hit     = 1'b1;
            w_hit_idx = IDX_W'(i);
         end
         if (r_valid[i] && (r_entry[i].vpn == bus.new_ea[31:12])) begin
            w_dup     = 1'b1;
            w_dup_idx = IDX_W'(i);
         end
         if (!r_valid[i]) begin
            w_free     = 1'b1;
            w_free_idx = IDX_W'(i);
         end
         w_inval_mask[i] = r_valid[i] &&
            (r_entry[i].vpn[INVAL_BITS-1:0] == bus.inval_ea[12+INVAL_BITS-1:12]);
      end
   end

   assign w_hit_entry   = r_entry[w_hit_idx];
   assign w_victim      = w_dup ? w_dup_idx : (w_free ? w_free_idx : r_rr);
   assign w_inval_all   = (bus.invalidate == 2'b01);
   assign w_inval_ea    = (bus.invalidate == 2'b10);
   assign w_do_load     = bus.load && !w_inval_all && !w_inval_ea;
   assign w_unused_addr = ^{bus.lookup_ea[11:0], bus.new_ea[11:0], bus.new_pa[11:0], bus.inval_ea};

   // Valid bits and round-robin pointer; an invalidate drops a same-cycle fill.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= '0;
         r_rr    <= '0;
      end else if (w_inval_all) begin
         r_valid <= '0;
      end else if (w_inval_ea) begin
         r_valid <= r_valid & ~w_inval_mask;
      end else if (w_do_load) begin
         r_valid[w_victim] <= 1'b1;
         if (!w_dup && !w_free)
            r_rr <= (r_rr == IDX_W'(ENTRIES - 1)) ? '0 : r_rr + IDX_W'(1);
      end
   end

   // Translation payload carries no reset; valid bits gate every use of it.
   always_ff @(posedge clk) begin
      if (w_do_load)
         r_entry[w_victim] <= {bus.new_ea[31:12], bus.new_pa[31:12], bus.new_pp,
                               bus.new_Ks, bus.new_Kp, bus.new_cacheable};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.rsp_valid     <= 1'b0;
         bus.rsp_hit       <= 1'b0;
         bus.rsp_pa        <= '0;
         bus.rsp_pp        <= '0;
         bus.rsp_Ks        <= 1'b0;
         bus.rsp_Kp        <= 1'b0;
         bus.rsp_cacheable <= 1'b0;
      end else begin
         bus.rsp_valid <= bus.lookup_valid;
         if (bus.lookup_valid && w_hit) begin
            bus.rsp_hit       <= 1'b1;
            bus.rsp_pa        <= {w_hit_entry.ppn, 12'h000};
            bus.rsp_pp        <= (INSTRUCTION != 0) ? 2'b00 : w_hit_entry.pp;
            bus.rsp_Ks        <= (INSTRUCTION != 0) ? 1'b0 : w_hit_entry.ks;
            bus.rsp_Kp        <= w_hit_entry.kp;
            bus.rsp_cacheable <= w_hit_entry.wb;
         end else begin
            bus.rsp_hit       <= 1'b0;
            bus.rsp_pa        <= '0;
            bus.rsp_pp        <= '0;
            bus.rsp_Ks        <= 1'b0;
            bus.rsp_Kp        <= 1'b0;
            bus.rsp_cacheable <= 1'b0;
         end
      end
   end

`ifdef TLB_ARRAY_STATS_EN
   // Counted on the edge that registers the response; clear beats increment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.hit_count  <= '0;
         bus.miss_count <= '0;
      end else if (bus.stats_clear) begin
         bus.hit_count  <= '0;
         bus.miss_count <= '0;
      end else if (bus.lookup_valid) begin
         if (w_hit) begin
            if (bus.hit_count != 16'hFFFF)
               bus.hit_count <= bus.hit_count + 16'd1;
         end else begin
            if (bus.miss_count != 16'hFFFF)
               bus.miss_count <= bus.miss_count + 16'd1;
         end
      end
   end
`else
   logic w_unused_stats;
   assign w_unused_stats = bus.stats_clear;
   assign bus.hit_count  = '0;
   assign bus.miss_count = '0;
`endif
endmodule

// File: tb/tb_tlb_array.sv
// Bench for tlb_array (ENTRIES=4): directed table, corner sequences and randomized traffic
// checked against an array-based reference model. Honors TLB_ARRAY_STATS_EN.
module tb_tlb_array;
   localparam int N  = 4;
   localparam int IB = 6;

   typedef struct {
      logic        lv;
      logic [31:0] lea;
      logic        ld;
      logic [31:0] nea;
      logic [31:0] npa;
      logic [1:0]  npp;
      logic        nkp;
      logic        nks;
      logic        nc;
      logic [1:0]  inv;
      logic [31:0] iea;
      logic        sc;
   } in_t;

   typedef struct {
      logic        valid;
      logic        hit;
      logic [31:0] pa;
      logic [1:0]  pp;
      logic        ks;
      logic        kp;
      logic        c;
   } rsp_t;

   typedef struct {
      string       name;
      in_t         s;
      logic        hit;
      logic [31:0] pa;
      logic [1:0]  pp;
      logic        c;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   tlb_array_if bus ();
   tlb_array #(.ENTRIES(N), .INSTRUCTION(0), .INVAL_BITS(IB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: plain arrays updated by the fill/invalidate rules.
   bit          m_valid [N];
   logic [19:0] m_vpn   [N];
   logic [19:0] m_ppn   [N];
   logic [1:0]  m_pp    [N];
   logic        m_ks    [N];
   logic        m_kp    [N];
   logic        m_c     [N];
   int          m_rr     = 0;
   int          m_hits   = 0;
   int          m_misses = 0;
   vec_t        tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic in_t i_idle();
      in_t s;
      s = '{lv: 1'b0, lea: '0, ld: 1'b0, nea: '0, npa: '0, npp: '0, nkp: 1'b0, nks: 1'b0,
            nc: 1'b0, inv: 2'b00, iea: '0, sc: 1'b0};
      return s;
   endfunction

   function automatic in_t i_lk(input logic [31:0] ea);
      in_t s = i_idle();
      s.lv = 1'b1; s.lea = ea;
      return s;
   endfunction

   function automatic in_t i_ld(input logic [31:0] ea, input logic [31:0] pa,
                                input logic [1:0] pp, input logic c);
      in_t s = i_idle();
      s.ld = 1'b1; s.nea = ea; s.npa = pa; s.npp = pp; s.nc = c;
      return s;
   endfunction

   function automatic in_t i_inv(input logic [1:0] code, input logic [31:0] ea);
      in_t s = i_idle();
      s.inv = code; s.iea = ea;
      return s;
   endfunction

   function automatic void add(input string n, input in_t s, input logic h,
                               input logic [31:0] pa, input logic [1:0] pp, input logic c);
      vec_t v;
      v.name = n; v.s = s; v.hit = h; v.pa = pa; v.pp = pp; v.c = c;
      tbl.push_back(v);
   endfunction

   function automatic rsp_t model_lookup(input in_t s);
      rsp_t r = '{valid: s.lv, hit: 1'b0, pa: '0, pp: '0, ks: 1'b0, kp: 1'b0, c: 1'b0};
      if (s.lv) begin
         for (int i = 0; i < N; i++) begin
            if (!r.hit && m_valid[i] && m_vpn[i] == s.lea[31:12]) begin
               r.hit = 1'b1; r.pa = {m_ppn[i], 12'h000};
               r.pp = m_pp[i]; r.ks = m_ks[i]; r.kp = m_kp[i]; r.c = m_c[i];
            end
         end
      end
      return r;
   endfunction

   function automatic void model_update(input in_t s, input logic hit);
      int v = -1;
`ifdef TLB_ARRAY_STATS_EN
      if (s.sc) begin
         m_hits = 0; m_misses = 0;
      end else if (s.lv) begin
         if (hit) m_hits = (m_hits == 65535) ? 65535 : m_hits + 1;
         else     m_misses = (m_misses == 65535) ? 65535 : m_misses + 1;
      end
`endif
      if (s.inv == 2'b01) begin
         for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
      end else if (s.inv == 2'b10) begin
         for (int i = 0; i < N; i++)
            if (m_vpn[i][IB-1:0] == s.iea[12+IB-1:12]) m_valid[i] = 1'b0;
      end else if (s.ld) begin
         for (int i = 0; i < N; i++)
            if (v < 0 && m_valid[i] && m_vpn[i] == s.nea[31:12]) v = i;
         for (int i = 0; i < N; i++)
            if (v < 0 && !m_valid[i]) v = i;
         if (v < 0) begin
            v = m_rr; m_rr = (m_rr + 1) % N;
         end
         m_valid[v] = 1'b1; m_vpn[v] = s.nea[31:12]; m_ppn[v] = s.npa[31:12];
         m_pp[v] = s.npp; m_ks[v] = s.nks; m_kp[v] = s.nkp; m_c[v] = s.nc;
      end
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
      m_rr = 0; m_hits = 0; m_misses = 0;
   endfunction

   // One clock: drive at negedge, predict from pre-edge state, sample 1ns after the edge.
   task automatic run_cycle(input in_t s, input bit chk);
      rsp_t e;
      @(negedge clk);
      bus.lookup_valid = s.lv;  bus.lookup_ea = s.lea;
      bus.load = s.ld;          bus.new_ea = s.nea;      bus.new_pa = s.npa;
      bus.new_pp = s.npp;       bus.new_Kp = s.nkp;      bus.new_Ks = s.nks;
      bus.new_cacheable = s.nc; bus.invalidate = s.inv;  bus.inval_ea = s.iea;
      bus.stats_clear = s.sc;
      e = model_lookup(s);
      @(posedge clk);
      model_update(s, e.hit);
      #1;
      if (chk) begin
         check("rsp_valid", 32'(bus.rsp_valid), 32'(e.valid));
         check("rsp_hit", 32'(bus.rsp_hit), 32'(e.hit));
         check("rsp_pa", bus.rsp_pa, e.pa);
         check("rsp_attr", 32'({bus.rsp_pp, bus.rsp_Ks, bus.rsp_Kp, bus.rsp_cacheable}),
               32'({e.pp, e.ks, e.kp, e.c}));
         check("hit_count", 32'(bus.hit_count), 32'(m_hits));
         check("miss_count", 32'(bus.miss_count), 32'(m_misses));
      end
   endtask

   initial begin
      in_t s;
      reset = 1'b0;
      s = i_idle();
      bus.lookup_valid = 1'b0; bus.lookup_ea = '0; bus.load = 1'b0; bus.new_ea = '0;
      bus.new_pa = '0; bus.new_pp = '0; bus.new_Kp = 1'b0; bus.new_Ks = 1'b0;
      bus.new_cacheable = 1'b0; bus.invalidate = '0; bus.inval_ea = '0; bus.stats_clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("reset rsp_pa", bus.rsp_pa, 32'd0);
      check("reset rsp_attr", 32'({bus.rsp_hit, bus.rsp_pp, bus.rsp_Ks, bus.rsp_Kp, bus.rsp_cacheable}), 32'd0);
      check("reset counts", {bus.hit_count, bus.miss_count}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Directed table: one row per cycle with the response expected from that row's lookup.
      add("fill0",  i_ld(32'h1234_5000, 32'h8000_0000, 2'd2, 1'b1), 0, 0, 0, 0);
      add("hit0",   i_lk(32'h1234_5ABC), 1, 32'h8000_0000, 2'd2, 1'b1);
      add("miss0",  i_lk(32'h1234_6000), 0, 0, 0, 0);
      add("clr0",   i_inv(2'b01, 0), 0, 0, 0, 0);
      add("ldA",    i_ld(32'h1000_0000, 32'hA000_0000, 2'd0, 1'b1), 0, 0, 0, 0);
      add("ldB",    i_ld(32'h2000_0000, 32'hB000_0000, 2'd1, 1'b0), 0, 0, 0, 0);
      add("ldC",    i_ld(32'h3000_0000, 32'hC000_0000, 2'd2, 1'b1), 0, 0, 0, 0);
      add("ldD",    i_ld(32'h4000_0000, 32'hD000_0000, 2'd3, 1'b0), 0, 0, 0, 0);
      add("lkA",    i_lk(32'h1000_0123), 1, 32'hA000_0000, 2'd0, 1'b1);
      add("lkD",    i_lk(32'h4000_0FFF), 1, 32'hD000_0000, 2'd3, 1'b0);
      add("ldE",    i_ld(32'h5000_0000, 32'hE000_0000, 2'd1, 1'b1), 0, 0, 0, 0);
      add("lkA_ev", i_lk(32'h1000_0000), 0, 0, 0, 0);
      add("lkE",    i_lk(32'h5000_0000), 1, 32'hE000_0000, 2'd1, 1'b1);
      add("ldF",    i_ld(32'h6000_0000, 32'hF000_0000, 2'd2, 1'b0), 0, 0, 0, 0);
      add("lkB_ev", i_lk(32'h2000_0000), 0, 0, 0, 0);
      add("lkF",    i_lk(32'h6000_0000), 1, 32'hF000_0000, 2'd2, 1'b0);
      add("lkC",    i_lk(32'h3000_0000), 1, 32'hC000_0000, 2'd2, 1'b1);
      add("clr1",   i_inv(2'b01, 0), 0, 0, 0, 0);
      add("ldG1",   i_ld(32'h7000_0000, 32'h1111_1000, 2'd1, 1'b0), 0, 0, 0, 0);
      add("ldG2",   i_ld(32'h7000_0000, 32'h2222_2000, 2'd3, 1'b1), 0, 0, 0, 0);
      add("lkG",    i_lk(32'h7000_0000), 1, 32'h2222_2000, 2'd3, 1'b1);
      add("ldH",    i_ld(32'h7100_0000, 32'h3333_3000, 2'd0, 1'b0), 0, 0, 0, 0);
      add("ldI",    i_ld(32'h7200_0000, 32'h4444_4000, 2'd0, 1'b0), 0, 0, 0, 0);
      add("ldJ",    i_ld(32'h7300_0000, 32'h5555_5000, 2'd0, 1'b1), 0, 0, 0, 0);
      add("lkG2",   i_lk(32'h7000_0000), 1, 32'h2222_2000, 2'd3, 1'b1);
      add("lkH",    i_lk(32'h7100_0000), 1, 32'h3333_3000, 2'd0, 1'b0);
      add("lkJ",    i_lk(32'h7300_0000), 1, 32'h5555_5000, 2'd0, 1'b1);
      add("clr2",   i_inv(2'b01, 0), 0, 0, 0, 0);
      add("ldX0",   i_ld(32'h0001_2000, 32'h0AAA_A000, 2'd1, 1'b1), 0, 0, 0, 0);
      add("ldX1",   i_ld(32'h0041_2000, 32'h0BBB_B000, 2'd1, 1'b1), 0, 0, 0, 0);
      add("ldX2",   i_ld(32'h0001_3000, 32'h0CCC_C000, 2'd1, 1'b1), 0, 0, 0, 0);
      add("invEA",  i_inv(2'b10, 32'h0001_2000), 0, 0, 0, 0);
      add("lkX0",   i_lk(32'h0001_2000), 0, 0, 0, 0);
      add("lkX1",   i_lk(32'h0041_2000), 0, 0, 0, 0);
      add("lkX2",   i_lk(32'h0001_3000), 1, 32'h0CCC_C000, 2'd1, 1'b1);
      add("invAll", i_inv(2'b01, 0), 0, 0, 0, 0);
      add("lkX2b",  i_lk(32'h0001_3000), 0, 0, 0, 0);
      s = i_inv(2'b01, 0); s.ld = 1'b1; s.nea = 32'h0800_0000; s.npa = 32'h0900_0000;
      add("inv+ld", s, 0, 0, 0, 0);
      add("lkK0",   i_lk(32'h0800_0000), 0, 0, 0, 0);
      add("ldA2",   i_ld(32'h1000_0000, 32'hA000_0000, 2'd0, 1'b1), 0, 0, 0, 0);
      s = i_inv(2'b01, 0); s.lv = 1'b1; s.lea = 32'h1000_0000;
      add("lk+inv", s, 1, 32'hA000_0000, 2'd0, 1'b1);
      add("lkA3",   i_lk(32'h1000_0000), 0, 0, 0, 0);
      s = i_ld(32'h0800_0000, 32'h0900_0000, 2'd2, 1'b0); s.lv = 1'b1; s.lea = 32'h0800_0000;
      add("lk+ld",  s, 0, 0, 0, 0);
      add("lkK1",   i_lk(32'h0800_0000), 1, 32'h0900_0000, 2'd2, 1'b0);

      foreach (tbl[k]) begin
         run_cycle(tbl[k].s, 1'b1);
         check({tbl[k].name, " valid"}, 32'(bus.rsp_valid), 32'(tbl[k].s.lv));
         check({tbl[k].name, " hit"}, 32'(bus.rsp_hit), 32'(tbl[k].hit));
         check({tbl[k].name, " pa"}, bus.rsp_pa, tbl[k].pa);
         check({tbl[k].name, " pp/c"}, 32'({bus.rsp_pp, bus.rsp_cacheable}), 32'({tbl[k].pp, tbl[k].c}));
      end

      // Statistics: clear, 3 hits + 2 misses, then clear racing a lookup.
      s = i_idle(); s.sc = 1'b1;
      run_cycle(s, 1'b1);
      check("stats cleared", {bus.hit_count, bus.miss_count}, 32'd0);
      for (int k = 0; k < 3; k++) run_cycle(i_lk(32'h0800_0000), 1'b1);
      for (int k = 0; k < 2; k++) run_cycle(i_lk(32'hDEAD_0000), 1'b1);
`ifdef TLB_ARRAY_STATS_EN
      check("stats 3/2", {bus.hit_count, bus.miss_count}, {16'd3, 16'd2});
`else
      check("stats off", {bus.hit_count, bus.miss_count}, 32'd0);
`endif
      s = i_lk(32'h0800_0000); s.sc = 1'b1;
      run_cycle(s, 1'b1);
      check("clear beats incr", {bus.hit_count, bus.miss_count}, 32'd0);
`ifdef TLB_ARRAY_STATS_EN
      for (int k = 0; k < 65540; k++) run_cycle(i_lk(32'h0800_0000), 1'b0);
      check("hit saturated", 32'(bus.hit_count), 32'h0000_FFFF);
      run_cycle(i_lk(32'h0800_0000), 1'b1);
      check("hit holds sat", 32'(bus.hit_count), 32'h0000_FFFF);
`endif

      // Reset in the middle of a cycle discards the registered response and the array.
      run_cycle(i_lk(32'h0800_0000), 1'b1);
      #1 reset = 1'b0;
      #1;
      model_reset();
      check("midreset rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("midreset rsp_pa", bus.rsp_pa, 32'd0);
      check("midreset counts", {bus.hit_count, bus.miss_count}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      run_cycle(i_lk(32'h0800_0000), 1'b1);
      check("post-reset miss", 32'(bus.rsp_hit), 32'd0);

      // Randomized traffic over a small VPN pool so hits, duplicates and evictions are common.
      for (int k = 0; k < 3000; k++) begin
         int unsigned r;
         s = i_idle();
         s.lv  = ($urandom_range(0, 9) < 6);
         s.lea = {14'($urandom_range(0, 2)), 6'($urandom_range(0, 3)), 12'($urandom)};
         s.ld  = ($urandom_range(0, 9) < 4);
         s.nea = {14'($urandom_range(0, 2)), 6'($urandom_range(0, 3)), 12'($urandom)};
         s.npa = $urandom;
         s.npp = 2'($urandom); s.nkp = 1'($urandom); s.nks = 1'($urandom); s.nc = 1'($urandom);
         r = $urandom_range(0, 99);
         s.inv = (r < 3) ? 2'b01 : (r < 10) ? 2'b10 : (r < 13) ? 2'b11 : 2'b00;
         s.iea = {14'($urandom), 6'($urandom_range(0, 3)), 12'($urandom)};
         s.sc  = ($urandom_range(0, 99) < 2);
         run_cycle(s, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
